alu_operand_gate: RTL and testbench

- Parametrised, registered successor to the ALU operand enable gate; sits between the operand source and the ALU datapath.
- Accepts an operand pair plus an enable flag over a valid/ready handshake.
- Gates the pair: pass-through when enabled; zeroed or held-last when disabled.
- Buffers gated pairs in a small FIFO so the source and the ALU can stall independently.

---
 rtl/alu_operand_gate.sv | 180 ++++++++++++++++++
 tb/tb_alu_operand_gate.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_gate.sv
// alu_operand_gate: registered operand gate with a small FIFO between the
// operand source and the ALU datapath.
// Optional statistics counters are enabled with `define ALU_OPERAND_GATE_STATS_EN.
module alu_operand_gate #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 2,
    parameter int HOLD_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             e,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             gated
`ifdef ALU_OPERAND_GATE_STATS_EN
    ,
    output logic [15:0]      xfer_cnt,
    output logic [15:0]      gated_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_a_r [DEPTH];
    logic [WIDTH-1:0] mem_b_r [DEPTH];
    logic             mem_g_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] hold_a_r;
    logic [WIDTH-1:0] hold_b_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] c_r;
    logic [WIDTH-1:0] d_r;
    logic             gated_r;

    logic             push_s;
    logic             pop_s;
    logic [WIDTH-1:0] wr_a_s;
    logic [WIDTH-1:0] wr_b_s;
    logic             wr_g_s;
    logic [AW-1:0]    wr_next_s;
    logic [AW-1:0]    rd_next_s;
    logic [CW-1:0]    count_next_s;
    logic [WIDTH-1:0] head_a_s;
    logic [WIDTH-1:0] head_b_s;
    logic             head_g_s;

    // Handshake qualification, gating of the incoming pair and next-state FIFO bookkeeping.
    always_comb begin
        push_s = in_valid && in_ready_r;
        pop_s  = out_valid_r && out_ready;

        if (e) begin
            wr_a_s = a;
            wr_b_s = b;
        end else if (HOLD_MODE != 0) begin
            wr_a_s = hold_a_r;
            wr_b_s = hold_b_r;
        end else begin
            wr_a_s = {WIDTH{1'b0}};
            wr_b_s = {WIDTH{1'b0}};
        end
        wr_g_s = ~e;

        // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally.
        wr_next_s = push_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
        rd_next_s = pop_s  ? (rd_ptr_r + AW'(1)) : rd_ptr_r;

        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase

        // Head after this edge: empty -> zeros; the pair being written lands at the head
        // only when nothing older remains; otherwise read the stored entry.
        if (count_next_s == CW'(0)) begin
            head_a_s = {WIDTH{1'b0}};
            head_b_s = {WIDTH{1'b0}};
            head_g_s = 1'b0;
        end else if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_a_s = wr_a_s;
            head_b_s = wr_b_s;
            head_g_s = wr_g_s;
        end else begin
            head_a_s = mem_a_r[rd_next_s];
            head_b_s = mem_b_r[rd_next_s];
            head_g_s = mem_g_r[rd_next_s];
        end
    end

    // FIFO storage written at the tail on every accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_r[i] <= {WIDTH{1'b0}};
                mem_b_r[i] <= {WIDTH{1'b0}};
                mem_g_r[i] <= 1'b0;
            end
        end else if (push_s) begin
            mem_a_r[wr_ptr_r] <= wr_a_s;
            mem_b_r[wr_ptr_r] <= wr_b_s;
            mem_g_r[wr_ptr_r] <= wr_g_s;
        end
    end

    // Pointers, occupancy and registered handshake/output view of the head entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            c_r         <= {WIDTH{1'b0}};
            d_r         <= {WIDTH{1'b0}};
            gated_r     <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_next_s;
            rd_ptr_r    <= rd_next_s;
            count_r     <= count_next_s;
            in_ready_r  <= (count_next_s < DEPTH_C);
            out_valid_r <= (count_next_s != CW'(0));
            c_r         <= head_a_s;
            d_r         <= head_b_s;
            gated_r     <= head_g_s;
        end
    end

    // Hold register tracks the most recent enabled pair in push order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_a_r <= {WIDTH{1'b0}};
            hold_b_r <= {WIDTH{1'b0}};
        end else if (push_s && e && (HOLD_MODE != 0)) begin
            hold_a_r <= a;
            hold_b_r <= b;
        end
    end

`ifdef ALU_OPERAND_GATE_STATS_EN
    logic [15:0] xfer_cnt_r;
    logic [15:0] gated_cnt_r;

    // Saturating pop counters; gated_r is the gated bit of the entry being popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_r  <= 16'h0000;
            gated_cnt_r <= 16'h0000;
        end else if (pop_s) begin
            if (xfer_cnt_r != 16'hFFFF) begin
                xfer_cnt_r <= xfer_cnt_r + 16'h0001;
            end
            if (gated_r && (gated_cnt_r != 16'hFFFF)) begin
                gated_cnt_r <= gated_cnt_r + 16'h0001;
            end
        end
    end

    assign xfer_cnt  = xfer_cnt_r;
    assign gated_cnt = gated_cnt_r;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign c         = c_r;
    assign d         = d_r;
    assign gated     = gated_r;

endmodule

// File: tb/tb_alu_operand_gate.sv
// Bench for alu_operand_gate: one instance in zero mode and one in hold mode,
// driven with identical stimulus and checked against a queue-based model.
module tb_alu_operand_gate;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       g;
    } entry_t;

    typedef struct packed {
        logic       iv;
        logic       e;
        logic [3:0] a;
        logic [3:0] b;
        logic       ordy;
        logic       ov;
        logic       ir;
        logic [3:0] c;
        logic [3:0] d;
        logic       g;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       e = 1'b0;
    logic [3:0] a = 4'h0;
    logic [3:0] b = 4'h0;
    logic       out_ready = 1'b0;

    logic       in_ready0, out_valid0, gated0;
    logic [3:0] c0, d0;
    logic       in_ready1, out_valid1, gated1;
    logic [3:0] c1, d1;
`ifdef ALU_OPERAND_GATE_STATS_EN
    logic [15:0] xfer_cnt0, gated_cnt0, xfer_cnt1, gated_cnt1;
    int          m_xfer, m_gated;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    entry_t     q0[$];
    entry_t     q1[$];
    logic [3:0] hold_a, hold_b;

    alu_operand_gate #(.WIDTH(4), .DEPTH(DEPTH), .HOLD_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .e(e), .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .c(c0), .d(d0), .gated(gated0)
`ifdef ALU_OPERAND_GATE_STATS_EN
        , .xfer_cnt(xfer_cnt0), .gated_cnt(gated_cnt0)
`endif
    );

    alu_operand_gate #(.WIDTH(4), .DEPTH(DEPTH), .HOLD_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .e(e), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .c(c1), .d(d1), .gated(gated1)
`ifdef ALU_OPERAND_GATE_STATS_EN
        , .xfer_cnt(xfer_cnt1), .gated_cnt(gated_cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        hold_a = 4'h0;
        hold_b = 4'h0;
`ifdef ALU_OPERAND_GATE_STATS_EN
        m_xfer  = 0;
        m_gated = 0;
`endif
    endtask

    // Model state as seen one edge later: pop the head, then append the gated pair.
    task automatic model_edge();
        logic   push_ok, pop_ok;
        entry_t n0, n1, popped;
        push_ok = in_valid && (q0.size() < DEPTH);
        pop_ok  = out_ready && (q0.size() != 0);
        if (pop_ok) begin
            popped = q0.pop_front();
            void'(q1.pop_front());
`ifdef ALU_OPERAND_GATE_STATS_EN
            if (m_xfer < 65535) m_xfer++;
            if (popped.g && m_gated < 65535) m_gated++;
`endif
        end
        if (push_ok) begin
            n0 = e ? '{a: a, b: b, g: 1'b0} : '{a: 4'h0, b: 4'h0, g: 1'b1};
            n1 = e ? '{a: a, b: b, g: 1'b0} : '{a: hold_a, b: hold_b, g: 1'b1};
            if (e) begin
                hold_a = a;
                hold_b = b;
            end
            q0.push_back(n0);
            q1.push_back(n1);
        end
    endtask

    task automatic compare_model();
        entry_t h0, h1;
        h0 = '0;
        h1 = '0;
        if (q0.size() != 0) h0 = q0[0];
        if (q1.size() != 0) h1 = q1[0];
        check("count_bound", (q0.size() <= DEPTH), 1);
        check("out_valid0", out_valid0, q0.size() != 0);
        check("in_ready0",  in_ready0,  q0.size() < DEPTH);
        check("c0", c0, h0.a);
        check("d0", d0, h0.b);
        check("gated0", gated0, h0.g);
        check("out_valid1", out_valid1, q1.size() != 0);
        check("in_ready1",  in_ready1,  q1.size() < DEPTH);
        check("c1", c1, h1.a);
        check("d1", d1, h1.b);
        check("gated1", gated1, h1.g);
`ifdef ALU_OPERAND_GATE_STATS_EN
        check("xfer_cnt0",  xfer_cnt0,  m_xfer);
        check("gated_cnt0", gated_cnt0, m_gated);
        check("xfer_cnt1",  xfer_cnt1,  m_xfer);
`endif
    endtask

    task automatic step(input logic iv, input logic ee, input logic [3:0] aa,
                        input logic [3:0] bb, input logic ordy);
        in_valid  = iv;
        e         = ee;
        a         = aa;
        b         = bb;
        out_ready = ordy;
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid0"}, out_valid0, 0);
        check({tag, "_in_ready0"},  in_ready0,  0);
        check({tag, "_c0"}, c0, 0);
        check({tag, "_d0"}, d0, 0);
        check({tag, "_gated0"}, gated0, 0);
        check({tag, "_out_valid1"}, out_valid1, 0);
        check({tag, "_c1"}, c1, 0);
        check({tag, "_d1"}, d1, 0);
    endtask

    vec_t tbl[10];

    initial begin
        // Directed vectors for the zero-mode instance: inputs, then outputs after the edge.
        tbl[0] = '{iv:1'b1, e:1'b1, a:4'hA, b:4'h5, ordy:1'b1, ov:1'b1, ir:1'b1, c:4'hA, d:4'h5, g:1'b0};
        tbl[1] = '{iv:1'b0, e:1'b0, a:4'h0, b:4'h0, ordy:1'b1, ov:1'b0, ir:1'b1, c:4'h0, d:4'h0, g:1'b0};
        tbl[2] = '{iv:1'b1, e:1'b0, a:4'hF, b:4'hF, ordy:1'b0, ov:1'b1, ir:1'b1, c:4'h0, d:4'h0, g:1'b1};
        tbl[3] = '{iv:1'b0, e:1'b0, a:4'h0, b:4'h0, ordy:1'b1, ov:1'b0, ir:1'b1, c:4'h0, d:4'h0, g:1'b0};
        tbl[4] = '{iv:1'b1, e:1'b1, a:4'h1, b:4'h1, ordy:1'b0, ov:1'b1, ir:1'b1, c:4'h1, d:4'h1, g:1'b0};
        tbl[5] = '{iv:1'b1, e:1'b1, a:4'h2, b:4'h2, ordy:1'b0, ov:1'b1, ir:1'b0, c:4'h1, d:4'h1, g:1'b0};
        tbl[6] = '{iv:1'b1, e:1'b1, a:4'h3, b:4'h3, ordy:1'b0, ov:1'b1, ir:1'b0, c:4'h1, d:4'h1, g:1'b0};
        tbl[7] = '{iv:1'b1, e:1'b1, a:4'h3, b:4'h3, ordy:1'b1, ov:1'b1, ir:1'b1, c:4'h2, d:4'h2, g:1'b0};
        tbl[8] = '{iv:1'b1, e:1'b1, a:4'h3, b:4'h3, ordy:1'b1, ov:1'b1, ir:1'b1, c:4'h3, d:4'h3, g:1'b0};
        tbl[9] = '{iv:1'b0, e:1'b0, a:4'h0, b:4'h0, ordy:1'b1, ov:1'b0, ir:1'b1, c:4'h0, d:4'h0, g:1'b0};

        model_reset();
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        check("post_rst_in_ready", in_ready0, 1);

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].iv, tbl[i].e, tbl[i].a, tbl[i].b, tbl[i].ordy);
            check($sformatf("vec%0d_out_valid", i), out_valid0, tbl[i].ov);
            check($sformatf("vec%0d_in_ready", i),  in_ready0,  tbl[i].ir);
            check($sformatf("vec%0d_c", i), c0, tbl[i].c);
            check($sformatf("vec%0d_d", i), d0, tbl[i].d);
            check($sformatf("vec%0d_gated", i), gated0, tbl[i].g);
        end

        // Hold mode: a disabled push reuses the last enabled pair.
        step(1'b1, 1'b1, 4'h3, 4'h9, 1'b1);
        step(1'b1, 1'b0, 4'hF, 4'hF, 1'b1);
        check("hold_c1", c1, 4'h3);
        check("hold_d1", d1, 4'h9);
        check("hold_gated1", gated1, 1);
        check("zero_c0", c0, 4'h0);
        check("zero_d0", d0, 4'h0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);

        // Random concurrent push/pop traffic.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                 4'($urandom), 1'($urandom_range(0, 1)));
        end
        repeat (3) step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);

        // Mid-operation reset with two entries queued.
        step(1'b1, 1'b1, 4'h6, 4'h7, 1'b0);
        step(1'b1, 1'b1, 4'h8, 4'h9, 1'b0);
        check("pre_rst_full", in_ready0, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        model_reset();
`ifdef ALU_OPERAND_GATE_STATS_EN
        check("mid_xfer_cnt",  xfer_cnt0,  0);
        check("mid_gated_cnt", gated_cnt0, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        check("rel_empty", out_valid0, 0);
        step(1'b1, 1'b0, 4'hF, 4'hF, 1'b0);
        check("rel_hold_c1", c1, 4'h0);
        check("rel_hold_d1", d1, 4'h0);
        check("rel_hold_g1", gated1, 1);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
